dmem_ctrl: RTL

- Parametrised single-clock data memory for the CPU.
- Byte-lane storage with store-lane generation from size/offset, and load alignment with sign/zero extension.
- Detects misaligned and out-of-range accesses.
- Includes a programming (UART upgrade) port and a PROG/RUN mode state machine that gates which side owns the array.

---
 rtl/dmem_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- single-clock CPU data memory with byte-lane stores, aligned
// loads with sign/zero extension, alignment/range error reporting and a
// programming (upgrade) port. A PROG/RUN state machine decides who owns the
// array: in PROG only the upgrade port writes, in RUN only the CPU accesses it.
//
// Parameters
//   DATA_W  word width in bits, multiple of 8 and at least 32
//   DEPTH   number of words, power of two
//   ADDR_W  CPU byte-address width
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req, we             CPU access request, 1 = store / 0 = load
//   addr, size          byte address, 00 byte / 01 half / 1x word
//   sign_ext            load extension select
//   wdata               right-aligned store data
//   rdata, rvalid       formatted load data and its 1-cycle valid
//   err_align           misaligned access pulse
//   err_range           out-of-range access pulse
//   ready               high while in RUN
//   upg_mode            programming request level (rising edge enters PROG)
//   upg_wen, upg_adr,
//   upg_dat             programming word write
//   upg_done            programming complete pulse (PROG -> RUN)
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [1:0]               size,
  input  logic                     sign_ext,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     err_align,
  output logic                     err_range,
  output logic                     ready,
  input  logic                     upg_mode,
  input  logic                     upg_wen,
  input  logic [$clog2(DEPTH)-1:0] upg_adr,
  input  logic [DATA_W-1:0]        upg_dat,
  input  logic                     upg_done
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    S_PROG = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_acc;
  logic              w_mis;
  logic              w_oor;
  logic              w_cpu_wr;
  logic              w_upg_wr;
  logic              w_upg_rise;
  logic [LANES-1:0]  w_be;
  logic [DATA_W-1:0] w_wrep;
  logic [DATA_W-1:0] w_fmt;

  logic              r_upg_q;
  logic              r_rvalid;
  logic              r_ld_err;
  logic              r_err_align;
  logic              r_err_range;
  logic [DATA_W-1:0] r_rdata_hold;
  logic [DATA_W-1:0] r_raw;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_sext;

  // Select the addressed bytes, move them to bit 0 and extend to DATA_W.
  function automatic logic [DATA_W-1:0] f_load(input logic [DATA_W-1:0] raw,
                                               input logic [OFF_W-1:0]  off,
                                               input logic [1:0]        sz,
                                               input logic              sx);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sh = raw >> {off, 3'b000};
    case (sz)
      2'b00:   res = {{(DATA_W-8){sx & sh[7]}}, sh[7:0]};
      2'b01:   res = {{(DATA_W-16){sx & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Request decode
  assign w_off = addr[OFF_W-1:0];
  assign w_idx = addr[IDX_W+OFF_W-1:OFF_W];
  assign w_oor = |addr[ADDR_W-1:IDX_W+OFF_W];

  always_comb begin
    w_mis = 1'b0;
    case (size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = addr[0];
      default: w_mis = (w_off != '0);
    endcase
  end

  // In the cycle RUN->PROG is decided the state is still RUN, so that access
  // is serviced.
  assign w_acc      = req & (r_state == S_RUN);
  assign w_cpu_wr   = w_acc & we & ~w_mis & ~w_oor;
  assign w_upg_wr   = (r_state == S_PROG) & upg_wen;
  assign w_upg_rise = upg_mode & ~r_upg_q;

  // Lane enables and replicated store data: every lane carries the slice of
  // wdata it would receive, so only the enables depend on the offset.
  always_comb begin
    w_be   = '0;
    w_wrep = wdata;
    for (int i = 0; i < LANES; i++) begin
      case (size)
        2'b00: begin
          w_be[i]          = (w_off == OFF_W'(i));
          w_wrep[8*i +: 8] = wdata[7:0];
        end
        2'b01: begin
          w_be[i]          = (w_off == OFF_W'(i)) || ((w_off + OFF_W'(1)) == OFF_W'(i));
          w_wrep[8*i +: 8] = wdata[8*(i%2) +: 8];
        end
        default: begin
          w_be[i] = 1'b1;
        end
      endcase
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_PROG;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PROG:  if (upg_done)   w_next = S_RUN;
      S_RUN:   if (w_upg_rise) w_next = S_PROG;
      default: w_next = S_PROG;
    endcase
  end

  // Stage p0 -> p1: array write and raw read (array is not reset)
  always_ff @(posedge clk) begin
    if (w_upg_wr) begin
      r_mem[upg_adr] <= upg_dat;
    end else if (w_cpu_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
    r_raw  <= r_mem[w_idx];
    r_off  <= w_off;
    r_size <= size;
    r_sext <= sign_ext;
  end

  // Stage p0 -> p1: response control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upg_q      <= 1'b0;
      r_rvalid     <= 1'b0;
      r_ld_err     <= 1'b0;
      r_err_align  <= 1'b0;
      r_err_range  <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_upg_q     <= upg_mode;
      r_rvalid    <= w_acc & ~we;
      r_ld_err    <= w_mis | w_oor;
      r_err_align <= w_acc & w_mis;
      r_err_range <= w_acc & ~w_mis & w_oor;
      if (r_rvalid) r_rdata_hold <= rdata;
    end
  end

  // Stage p1: format the registered read; errored loads return zero and
  // rdata keeps the last delivered value between loads.
  assign w_fmt     = r_ld_err ? '0 : f_load(r_raw, r_off, r_size, r_sext);
  assign rdata     = r_rvalid ? w_fmt : r_rdata_hold;
  assign rvalid    = r_rvalid;
  assign err_align = r_err_align;
  assign err_range = r_err_range;
  assign ready     = (r_state == S_RUN);

endmodule
